// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared constants for the write-back unit: CSR addresses, load funct3 codes
// and the commit FSM state encoding.
package ysyx_25020037_wbu_pkg;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25020037_load_ext.sv
// Combinational load data alignment and sign/zero extension.
// Unsupported funct3 codes return zero data and flag illegal.
module ysyx_25020037_load_ext
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data     = '0;
    illegal  = 1'b0;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword loads only look at addr_lo[1]; bit 0 is don't-care.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: begin
        data    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back / commit unit. Accepts one retired instruction per handshake,
// waits for load data when needed and produces a single registered commit
// cycle carrying GPR/CSR write strobes and ecall/mret side effects.
//
// Handshake: an instruction transfers on a clk edge where in_valid && in_ready;
// load data transfers on an edge where mem_rvalid && mem_rready. in_ready is
// high in IDLE and COMMIT, mem_rready only in WAIT_MEM; mem_rvalid is ignored
// everywhere else.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_rf_wen,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic            in_csr_wen,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_csr_wdata,
  input  logic            in_ecall,
  input  logic            in_mret,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            gpr_wen,
  output logic [XLEN-1:0] csr_wcsr_data,
  output logic            csrs_mtvec_wen,
  output logic            csrs_mepc_wen,
  output logic            csrs_mstatus_wen,
  output logic            csrs_mcause_wen,
  output logic            ecall_en,
  output logic            mret_en,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            wb_err
);

  localparam bit          TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  wbu_state_e state, state_n;

  // Fields of the instruction held while waiting for load data.
  logic [XLEN-1:0] l_pc;
  logic [4:0]      l_rd;
  logic            l_rf_wen;
  logic [2:0]      l_funct3;
  logic [1:0]      l_addr_lo;
  logic            l_csr_wen;
  logic [11:0]     l_csr_addr;
  logic [XLEN-1:0] l_csr_wdata;
  logic            l_ecall;
  logic            l_mret;
  logic [31:0]     tmo_cnt;

  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;

  logic            accept;
  logic            from_mem;
  logic            commit_n;
  logic [XLEN-1:0] s_pc;
  logic [4:0]      s_rd;
  logic            s_rf_wen;
  logic [XLEN-1:0] s_wdata;
  logic            s_err;
  logic            s_csr_wen;
  logic [11:0]     s_csr_addr;
  logic [XLEN-1:0] s_csr_wdata;
  logic            s_ecall;
  logic            s_mret;
  logic            ecall_n, mret_n;
  logic            mtvec_n, mepc_n, mstatus_n, mcause_n;

  ysyx_25020037_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3  (l_funct3),
    .addr_lo (l_addr_lo),
    .rdata   (mem_rdata),
    .data    (ext_data),
    .illegal (ext_illegal)
  );

  assign accept = in_valid && in_ready;

  // Next state and the contents of the upcoming commit cycle.
  always_comb begin
    state_n     = state;
    from_mem    = (state == S_WAIT_MEM);
    s_pc        = in_pc;
    s_rd        = in_rd;
    s_rf_wen    = in_rf_wen;
    s_wdata     = in_result;
    s_err       = 1'b0;
    s_csr_wen   = in_csr_wen;
    s_csr_addr  = in_csr_addr;
    s_csr_wdata = in_csr_wdata;
    s_ecall     = in_ecall;
    s_mret      = in_mret;
    ecall_n     = 1'b0;
    mret_n      = 1'b0;
    mtvec_n     = 1'b0;
    mepc_n      = 1'b0;
    mstatus_n   = 1'b0;
    mcause_n    = 1'b0;

    case (state)
      S_WAIT_MEM: begin
        if (mem_rvalid || (TMO_EN && tmo_cnt == TMO_LAST)) state_n = S_COMMIT;
        else state_n = S_WAIT_MEM;
      end
      default: begin
        if (accept) state_n = in_is_load ? S_WAIT_MEM : S_COMMIT;
        else state_n = S_IDLE;
      end
    endcase

    if (from_mem) begin
      s_pc        = l_pc;
      s_rd        = l_rd;
      s_rf_wen    = l_rf_wen;
      s_csr_wen   = l_csr_wen;
      s_csr_addr  = l_csr_addr;
      s_csr_wdata = l_csr_wdata;
      s_ecall     = l_ecall;
      s_mret      = l_mret;
      // Without rvalid the only way out of WAIT_MEM is the timeout.
      if (mem_rvalid) begin
        s_wdata = ext_illegal ? '0 : ext_data;
        s_err   = ext_illegal;
      end else begin
        s_wdata = '0;
        s_err   = 1'b1;
      end
    end

    commit_n = (state_n == S_COMMIT);

    // ecall beats mret beats explicit CSR writes.
    if (s_ecall) begin
      ecall_n = 1'b1;
    end else if (s_mret) begin
      mret_n = 1'b1;
    end else if (s_csr_wen) begin
      case (s_csr_addr)
        CSR_MTVEC:   mtvec_n   = 1'b1;
        CSR_MEPC:    mepc_n    = 1'b1;
        CSR_MSTATUS: mstatus_n = 1'b1;
        CSR_MCAUSE:  mcause_n  = 1'b1;
        default:     ;
      endcase
    end
  end

  // State register plus the instruction latch and memory timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      l_pc        <= '0;
      l_rd        <= '0;
      l_rf_wen    <= 1'b0;
      l_funct3    <= '0;
      l_addr_lo   <= '0;
      l_csr_wen   <= 1'b0;
      l_csr_addr  <= '0;
      l_csr_wdata <= '0;
      l_ecall     <= 1'b0;
      l_mret      <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        l_pc        <= in_pc;
        l_rd        <= in_rd;
        l_rf_wen    <= in_rf_wen;
        l_funct3    <= in_funct3;
        l_addr_lo   <= in_addr_lo;
        l_csr_wen   <= in_csr_wen;
        l_csr_addr  <= in_csr_addr;
        l_csr_wdata <= in_csr_wdata;
        l_ecall     <= in_ecall;
        l_mret      <= in_mret;
        tmo_cnt     <= '0;
      end else if (state == S_WAIT_MEM) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

  // Registered outputs: strobes live for exactly the cycle after commit_n.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready         <= 1'b1;
      mem_rready       <= 1'b0;
      commit_valid     <= 1'b0;
      wb_err           <= 1'b0;
      gpr_wen          <= 1'b0;
      csrs_mtvec_wen   <= 1'b0;
      csrs_mepc_wen    <= 1'b0;
      csrs_mstatus_wen <= 1'b0;
      csrs_mcause_wen  <= 1'b0;
      ecall_en         <= 1'b0;
      mret_en          <= 1'b0;
      gpr_waddr        <= '0;
      gpr_wdata        <= '0;
      csr_wcsr_data    <= '0;
      commit_pc        <= '0;
    end else begin
      in_ready         <= (state_n != S_WAIT_MEM);
      mem_rready       <= (state_n == S_WAIT_MEM);
      commit_valid     <= commit_n;
      wb_err           <= commit_n && s_err;
      gpr_wen          <= commit_n && s_rf_wen && (s_rd != 5'd0);
      csrs_mtvec_wen   <= commit_n && mtvec_n;
      csrs_mepc_wen    <= commit_n && mepc_n;
      csrs_mstatus_wen <= commit_n && mstatus_n;
      csrs_mcause_wen  <= commit_n && mcause_n;
      ecall_en         <= commit_n && ecall_n;
      mret_en          <= commit_n && mret_n;
      if (commit_n) begin
        gpr_waddr     <= s_rd;
        gpr_wdata     <= s_wdata;
        csr_wcsr_data <= s_csr_wdata;
        commit_pc     <= s_pc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Directed, table-driven bench for the write-back unit (MEM_TIMEOUT = 8).
module tb_ysyx_25020037_wbu;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_result, in_csr_wdata, mem_rdata;
  logic [4:0]  in_rd;
  logic        in_rf_wen, in_is_load, in_csr_wen, in_ecall, in_mret;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [11:0] in_csr_addr;
  logic        mem_rvalid, mem_rready;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata, csr_wcsr_data, commit_pc;
  logic        gpr_wen, csrs_mtvec_wen, csrs_mepc_wen, csrs_mstatus_wen, csrs_mcause_wen;
  logic        ecall_en, mret_en, commit_valid, wb_err;

  int errors = 0;
  int checks = 0;

  ysyx_25020037_wbu #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_result(in_result), .in_rf_wen(in_rf_wen),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .in_ecall(in_ecall), .in_mret(in_mret), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen), .csr_wcsr_data(csr_wcsr_data),
    .csrs_mtvec_wen(csrs_mtvec_wen), .csrs_mepc_wen(csrs_mepc_wen),
    .csrs_mstatus_wen(csrs_mstatus_wen), .csrs_mcause_wen(csrs_mcause_wen),
    .ecall_en(ecall_en), .mret_en(mret_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .wb_err(wb_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        rf_wen;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        ecall;
    logic        mret;
    logic        exp_gpr_wen;
    logic [3:0]  exp_csr;   // {mtvec, mepc, mstatus, mcause}
    logic        exp_ecall;
    logic        exp_mret;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_err;
  } ld_vec_t;

  alu_vec_t alu_tab[11];
  ld_vec_t  ld_tab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Step one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc = 0; in_rd = 0; in_result = 0; in_rf_wen = 0;
    in_is_load = 0; in_funct3 = 0; in_addr_lo = 0; in_csr_wen = 0;
    in_csr_addr = 0; in_csr_wdata = 0; in_ecall = 0; in_mret = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic drive_alu(input alu_vec_t v);
    in_valid = 1; in_is_load = 0; in_pc = v.pc; in_rd = v.rd; in_result = v.result;
    in_rf_wen = v.rf_wen; in_csr_wen = v.csr_wen; in_csr_addr = v.csr_addr;
    in_csr_wdata = v.csr_wdata; in_ecall = v.ecall; in_mret = v.mret;
  endtask

  task automatic check_alu(input alu_vec_t v);
    chk("alu commit_valid", 32'(commit_valid), 32'd1);
    chk("alu commit_pc", commit_pc, v.pc);
    chk("alu gpr_wen", 32'(gpr_wen), 32'(v.exp_gpr_wen));
    if (v.exp_gpr_wen) begin
      chk("alu gpr_waddr", 32'(gpr_waddr), 32'(v.rd));
      chk("alu gpr_wdata", gpr_wdata, v.result);
    end
    chk("alu csr strobes", 32'({csrs_mtvec_wen, csrs_mepc_wen, csrs_mstatus_wen, csrs_mcause_wen}),
        32'(v.exp_csr));
    if (v.exp_csr != 4'b0000) chk("alu csr_wcsr_data", csr_wcsr_data, v.csr_wdata);
    chk("alu ecall_en", 32'(ecall_en), 32'(v.exp_ecall));
    chk("alu mret_en", 32'(mret_en), 32'(v.exp_mret));
    chk("alu wb_err", 32'(wb_err), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    chk(name, 32'({commit_valid, gpr_wen, csrs_mtvec_wen, csrs_mepc_wen, csrs_mstatus_wen,
                   csrs_mcause_wen, ecall_en, mret_en, wb_err}), 32'd0);
  endtask

  task automatic run_load(input ld_vec_t v, input int idx);
    in_valid = 1; in_is_load = 1; in_pc = 32'h1000 + 32'(idx * 4); in_rd = 5'd10;
    in_result = 32'hCAFE_CAFE; in_rf_wen = 1; in_funct3 = v.funct3; in_addr_lo = v.addr_lo;
    in_csr_wen = 0; in_ecall = 0; in_mret = 0;
    tick();
    in_valid = 0;
    chk("ld mem_rready", 32'(mem_rready), 32'd1);
    chk("ld in_ready", 32'(in_ready), 32'd0);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk("ld wait commit_valid", 32'(commit_valid), 32'd0);
    end
    mem_rvalid = 1; mem_rdata = v.rdata;
    tick();
    mem_rvalid = 0; mem_rdata = 32'h5555_5555;
    chk("ld commit_valid", 32'(commit_valid), 32'd1);
    chk("ld gpr_wen", 32'(gpr_wen), 32'd1);
    chk("ld gpr_waddr", 32'(gpr_waddr), 32'd10);
    chk("ld gpr_wdata", gpr_wdata, v.exp_data);
    chk("ld wb_err", 32'(wb_err), 32'(v.exp_err));
    chk("ld commit_pc", commit_pc, 32'h1000 + 32'(idx * 4));
    tick();
    check_quiet("ld after commit quiet");
  endtask

  initial begin
    int n;
    alu_tab[0]  = '{32'h8000_0000, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 12'h000, 32'h0,          1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    alu_tab[1]  = '{32'h8000_0004, 5'd0, 32'h0000_0077, 1'b1, 1'b0, 12'h000, 32'h0,          1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    alu_tab[2]  = '{32'h8000_0008, 5'd0, 32'h0,         1'b0, 1'b1, 12'h305, 32'h8000_0100,   1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
    alu_tab[3]  = '{32'h8000_000C, 5'd0, 32'h0,         1'b0, 1'b1, 12'h305, 32'h8000_0100,   1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    alu_tab[4]  = '{32'h8000_0010, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, 12'h341, 32'h1111_2222,   1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0};
    alu_tab[5]  = '{32'h8000_0014, 5'd0, 32'h0,         1'b0, 1'b1, 12'h300, 32'h0000_1888,   1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
    alu_tab[6]  = '{32'h8000_0018, 5'd0, 32'h0,         1'b0, 1'b1, 12'h342, 32'h0000_000B,   1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
    alu_tab[7]  = '{32'h8000_001C, 5'd0, 32'h0,         1'b0, 1'b1, 12'h123, 32'h0000_0042,   1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    alu_tab[8]  = '{32'h8000_0020, 5'd0, 32'h0,         1'b0, 1'b1, 12'h300, 32'h0000_0080,   1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    alu_tab[9]  = '{32'h8000_0024, 5'd9, 32'h0000_0099, 1'b1, 1'b0, 12'h000, 32'h0,           1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
    alu_tab[10] = '{32'h8000_0028, 5'd3, 32'h0000_0033, 1'b0, 1'b0, 12'h000, 32'h0,           1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

    ld_tab[0] = '{3'b000, 2'd3, 32'h80FF_0000, 4, 32'hFFFF_FF80, 1'b0};
    ld_tab[1] = '{3'b101, 2'd2, 32'h80FF_0000, 1, 32'h0000_80FF, 1'b0};
    ld_tab[2] = '{3'b001, 2'd2, 32'h80FF_0000, 0, 32'hFFFF_80FF, 1'b0};
    ld_tab[3] = '{3'b001, 2'd3, 32'h80FF_0000, 2, 32'hFFFF_80FF, 1'b0};
    ld_tab[4] = '{3'b010, 2'd0, 32'h1234_5678, 2, 32'h1234_5678, 1'b0};
    ld_tab[5] = '{3'b100, 2'd1, 32'h0000_AB00, 3, 32'h0000_00AB, 1'b0};
    ld_tab[6] = '{3'b000, 2'd1, 32'h0000_7F00, 1, 32'h0000_007F, 1'b0};
    ld_tab[7] = '{3'b001, 2'd0, 32'h0000_8001, 0, 32'hFFFF_8001, 1'b0};
    ld_tab[8] = '{3'b011, 2'd0, 32'h1234_5678, 1, 32'h0000_0000, 1'b1};
    ld_tab[9] = '{3'b110, 2'd0, 32'h1234_5678, 0, 32'h0000_0000, 1'b1};

    // Reset
    clear_inputs();
    rst = 0;
    tick();
    tick();
    check_quiet("reset strobes");
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset mem_rready", 32'(mem_rready), 32'd0);
    chk("reset gpr_wdata", gpr_wdata, 32'd0);
    chk("reset commit_pc", commit_pc, 32'd0);
    rst = 1;
    tick();

    // Single non-load instructions, each followed by an idle cycle.
    for (int i = 0; i < 11; i++) begin
      drive_alu(alu_tab[i]);
      tick();
      in_valid = 0;
      check_alu(alu_tab[i]);
      tick();
      check_quiet("alu idle after commit");
    end

    // Loads with varying wait lengths.
    for (int i = 0; i < 10; i++) run_load(ld_tab[i], i);

    // mem_rvalid while idle must not do anything.
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 0;
    check_quiet("stray rvalid quiet");
    chk("stray rvalid mem_rready", 32'(mem_rready), 32'd0);

    // Back-to-back: three non-loads with in_valid held high.
    drive_alu(alu_tab[0]);
    tick();
    check_alu(alu_tab[0]);
    chk("b2b in_ready 1", 32'(in_ready), 32'd1);
    drive_alu(alu_tab[4]);
    tick();
    check_alu(alu_tab[4]);
    drive_alu(alu_tab[2]);
    tick();
    in_valid = 0;
    check_alu(alu_tab[2]);
    tick();
    check_quiet("b2b drained");

    // Load timeout: no rvalid, commit with error 8 cycles after acceptance.
    in_valid = 1; in_is_load = 1; in_pc = 32'h2000; in_rd = 5'd4; in_result = 32'h7777;
    in_rf_wen = 1; in_funct3 = 3'b010; in_addr_lo = 0; in_csr_wen = 0; in_ecall = 0; in_mret = 0;
    tick();
    in_valid = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (commit_valid) break;
    end
    chk("timeout cycles", 32'(n), 32'd8);
    chk("timeout commit_valid", 32'(commit_valid), 32'd1);
    chk("timeout wb_err", 32'(wb_err), 32'd1);
    chk("timeout gpr_wdata", gpr_wdata, 32'd0);
    chk("timeout gpr_wen", 32'(gpr_wen), 32'd1);
    chk("timeout commit_pc", commit_pc, 32'h2000);
    tick();
    check_quiet("timeout after quiet");

    // Reset in the middle of WAIT_MEM discards the load.
    in_valid = 1; in_is_load = 1; in_pc = 32'h3000; in_rd = 5'd6; in_rf_wen = 1;
    in_funct3 = 3'b010;
    tick();
    in_valid = 0;
    tick();
    chk("pre-reset mem_rready", 32'(mem_rready), 32'd1);
    rst = 0;
    tick();
    rst = 1;
    mem_rvalid = 1; mem_rdata = 32'hABCD_EF01;
    tick();
    mem_rvalid = 0;
    check_quiet("post-reset rvalid quiet");
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    chk("post-reset mem_rready", 32'(mem_rready), 32'd0);
    tick();
    check_quiet("post-reset late quiet");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
Write-back/commit unit and write-side initiator of the GPR/CSR register file. Accepts one retired instruction per handshake from EXU/LSU and waits for load data when needed. Sign/zero-extends loads, then drives one commit cycle of GPR and CSR write strobes, including the ecall and mret side-effects.

Parameters:
XLEN, 32, datapath width.
MEM_TIMEOUT, 0, max cycles spent in WAIT_MEM before forced error commit; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low
in_valid  input  1  instruction result valid
in_ready  output  1  unit can accept
in_pc  input  XLEN  instruction pc
in_rd  input  5  destination register
in_result  input  XLEN  ALU/CSR-read result for rd
in_rf_wen  input  1  instruction writes rd
in_is_load  input  1  rd gets memory data
in_funct3  input  3  load type
in_addr_lo  input  2  load address [1:0]
in_csr_wen  input  1  CSR write requested
in_csr_addr  input  12  CSR address
in_csr_wdata  input  XLEN  CSR write value
in_ecall  input  1  ecall retiring
in_mret  input  1  mret retiring
mem_rvalid  input  1  load data valid
mem_rready  output  1  ready for load data
mem_rdata  input  XLEN  raw load word
gpr_waddr  output  5  GPR write address
gpr_wdata  output  XLEN  GPR write data
gpr_wen  output  1  GPR write strobe
csr_wcsr_data  output  XLEN  CSR write data
csrs_mtvec_wen / csrs_mepc_wen / csrs_mstatus_wen / csrs_mcause_wen  output  1 each  CSR strobes
ecall_en  output  1  ecall commit strobe
mret_en  output  1  mret commit strobe
commit_valid  output  1  one-cycle retire pulse
commit_pc  output  XLEN  pc of retiring instruction
wb_err  output  1  one-cycle error pulse, coincident with commit_valid

Behaviour:
- All outputs are registered. Reset (rst==0 at a clk edge) sets state IDLE and all strobes, commit_valid and wb_err to 0; data outputs to 0.
- States: IDLE, WAIT_MEM, COMMIT. in_ready = (IDLE|COMMIT). mem_rready = WAIT_MEM.
- Accept on in_valid&&in_ready: latch all in_* fields.
  - is_load -> WAIT_MEM.
  - Otherwise -> COMMIT.
- WAIT_MEM: on mem_rvalid -> COMMIT with extended data.
  - A timeout counter is cleared on entry and increments each cycle. When MEM_TIMEOUT!=0 and count==MEM_TIMEOUT-1 without rvalid -> COMMIT with data 0 and wb_err=1.
- mem_rvalid outside WAIT_MEM is ignored.
- COMMIT lasts exactly one cycle and asserts commit_valid and the strobes. Next state:
  - accept in same cycle -> WAIT_MEM/COMMIT per new instruction;
  - else -> IDLE.
- Latency: non-load accepted at edge T gives strobes high in cycle T+1; load with rvalid sampled at edge R gives strobes in cycle R+1. Throughput: 1 non-load per cycle back-to-back.
- GPR: gpr_wen = rf_wen && rd!=0; gpr_waddr = rd; gpr_wdata = load ? extended : result.
- Load extension:
  - 000 lb: sign-extend byte addr_lo.
  - 001 lh: sign-extend half addr_lo[1]; addr_lo[0] is ignored.
  - 010 lw: full word.
  - 100 lbu / 101 lhu: zero-extend.
  - 011/110/111: data 0, wb_err=1.
- CSR: csr_wcsr_data = csr_wdata. Address decode:
  - 0x305 -> mtvec_wen; 0x341 -> mepc_wen; 0x300 -> mstatus_wen; 0x342 -> mcause_wen.
  - Any other address: no strobe and no error.
- ecall_en/mret_en pulse in COMMIT when latched. Priority ecall > mret > csr_wen: when ecall or mret is set, all csrs_*_wen stay 0 and mret is dropped if ecall is also set.
- commit_pc = latched pc. The GPR write still occurs with ecall/mret if rf_wen is set.
- Reset mid-WAIT_MEM: the transaction is discarded; no commit and no late strobes.

Decomposition:
- Package ysyx_25020037_wbu_pkg: CSR address constants (MTVEC/MEPC/MSTATUS/MCAUSE), load funct3 codes, state enum.
- Sub-module ysyx_25020037_load_ext: combinational (funct3, addr_lo, rdata) -> (data, illegal).

Test Plan:
- addi-like: in_rd=5, result=0x1234, rf_wen=1 -> next cycle gpr_wen=1, waddr=5, wdata=0x1234, commit_valid=1; following cycle all strobes 0.
- rd=0, rf_wen=1 -> gpr_wen stays 0, commit_valid=1.
- lb at addr_lo=3, rdata=0x80FF_0000 after 4 wait cycles -> wdata=0xFFFF_FF80 in the cycle after rvalid; lhu at addr_lo=2 -> 0x0000_80FF.
- csrw 0x305 data 0x8000_0100 -> csrs_mtvec_wen=1 only, csr_wcsr_data=0x8000_0100. The same instruction with in_ecall=1 -> ecall_en=1 and no csrs_* strobe.
- Back-to-back: 3 non-loads with in_valid held -> 3 consecutive commit_valid cycles. Load with MEM_TIMEOUT=8 and no rvalid -> commit 8 cycles after acceptance, wdata=0, wb_err=1.
- rst low during WAIT_MEM, then mem_rvalid -> no commit and no strobes; IDLE with in_ready=1 after reset releases.
